// File: rtl/kyber_pkg.sv
// Shared constants, state encoding and helpers for the Kyber sampler path.
package kyber_pkg;

  localparam int unsigned KYBER_N = 256;
  localparam int unsigned ETA_MAX = 3;
  localparam int unsigned BW_WORD = 64;
  localparam int unsigned BW_BUF  = 1536;
  localparam int unsigned BW_CNT  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } ibuf_state_t;

  // Number of 64-bit PRF words making up one 64*eta byte block.
  function automatic logic [BW_CNT-1:0] words_for_eta(input logic [1:0] eta);
    return BW_CNT'(eta) << 3;
  endfunction

endpackage

// File: rtl/cbd_ibuf_if.sv
// Upstream word stream, downstream block hand-off and status of cbd_ibuf.
interface cbd_ibuf_if;
  import kyber_pkg::*;

  logic               i_start;
  logic [1:0]         i_eta;
  logic [BW_WORD-1:0] i_word;
  logic               i_valid;
  logic               o_ready;
  logic [BW_BUF-1:0]  o_ibytes;
  logic [1:0]         o_eta;
  logic               o_valid;
  logic               i_ready;
  logic               o_busy;
  logic               o_err;

  // Environment side: PRF source, controller and cbd consumer.
  modport master (
    output i_start, i_eta, i_word, i_valid, i_ready,
    input  o_ready, o_ibytes, o_eta, o_valid, o_busy, o_err
  );

  // Buffer side.
  modport slave (
    input  i_start, i_eta, i_word, i_valid, i_ready,
    output o_ready, o_ibytes, o_eta, o_valid, o_busy, o_err
  );

endinterface

// File: rtl/cbd_ibuf.sv
// Single-entry byte buffer: collects 8*eta PRF words into one block for cbd.
module cbd_ibuf #(
  parameter int unsigned BW_WORD = kyber_pkg::BW_WORD,
  parameter int unsigned BW_BUF  = kyber_pkg::BW_BUF
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  cbd_ibuf_if.slave    bus
);
  import kyber_pkg::BW_CNT;
  import kyber_pkg::ibuf_state_t;
  import kyber_pkg::ST_IDLE;
  import kyber_pkg::ST_FILL;
  import kyber_pkg::ST_HOLD;
  import kyber_pkg::words_for_eta;

  localparam int unsigned NWORDS = BW_BUF / BW_WORD;

  ibuf_state_t        state_q, state_d;
  logic [BW_CNT-1:0]  cnt_q;
  logic [1:0]         eta_q;
  logic [BW_WORD-1:0] buf_q [NWORDS];
  logic               ready_q, ready_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               start_acc;
  logic               wr_en;
  logic               eta_ok;
  logic               last_word;
  logic [BW_BUF-1:0]  ibytes_c;

  assign eta_ok    = (bus.i_eta == 2'd2) || (bus.i_eta == 2'd3);
  assign last_word = (cnt_q == (words_for_eta(eta_q) - BW_CNT'(1)));

  // Next-state, start acceptance, word write enable and next registered outputs.
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    wr_en     = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          if (eta_ok) begin
            start_acc = 1'b1;
            state_d   = ST_FILL;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_FILL: begin
        if (bus.i_valid) begin
          wr_en = 1'b1;
          if (last_word) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.i_ready) begin
          if (bus.i_start && eta_ok) begin
            start_acc = 1'b1;
            state_d   = ST_FILL;
          end else begin
            err_d   = bus.i_start;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_FILL);
    valid_d = (state_d == ST_HOLD);
    busy_d  = (state_d != ST_IDLE);
  end

  // State, status outputs, counter and latched eta.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      eta_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      if (start_acc) begin
        cnt_q <= '0;
        eta_q <= bus.i_eta;
      end else if (wr_en) begin
        cnt_q <= cnt_q + BW_CNT'(1);
      end
    end
  end

  // Word slots: cleared on start, each written when the counter selects it.
  always_ff @(posedge i_clk) begin
    for (int j = 0; j < NWORDS; j++) begin
      if (!i_rstn || start_acc) begin
        buf_q[j] <= '0;
      end else if (wr_en && (cnt_q == BW_CNT'(j))) begin
        buf_q[j] <= bus.i_word;
      end
    end
  end

  // Flatten the word slots into the little-endian byte block.
  always_comb begin
    ibytes_c = '0;
    for (int j = 0; j < NWORDS; j++) begin
      ibytes_c[j*BW_WORD +: BW_WORD] = buf_q[j];
    end
  end

  assign bus.o_ibytes = ibytes_c;
  assign bus.o_eta    = eta_q;
  assign bus.o_ready  = ready_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_busy   = busy_q;
  assign bus.o_err    = err_q;

endmodule

// File: tb/tb_cbd_ibuf.sv
// Directed self-checking bench for cbd_ibuf.
module tb_cbd_ibuf;

  logic i_clk;
  logic i_rstn;
  int   n_tests;
  int   n_fail;

  cbd_ibuf_if bus ();

  cbd_ibuf dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .bus    (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Compare one observed value with its expected value and count it.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [63:0] word_at(input int n);
    logic [1535:0] b;
    b = bus.o_ibytes;
    return b[n*64 +: 64];
  endfunction

  function automatic logic [63:0] upper_or();
    logic [1535:0] b;
    b = bus.o_ibytes;
    return 64'(|b[1535:1024]);
  endfunction

  function automatic logic [63:0] all_or();
    logic [1535:0] b;
    b = bus.o_ibytes;
    return 64'(|b);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 64'(bus.o_ready), 64'd0);
    check({tag, "_valid"}, 64'(bus.o_valid), 64'd0);
    check({tag, "_busy"},  64'(bus.o_busy),  64'd0);
    check({tag, "_err"},   64'(bus.o_err),   64'd0);
    check({tag, "_eta"},   64'(bus.o_eta),   64'd0);
    check({tag, "_bytes"}, all_or(),         64'd0);
  endtask

  task automatic start_fill(input logic [1:0] eta);
    bus.i_start = 1'b1;
    bus.i_eta   = eta;
    step();
    bus.i_start = 1'b0;
  endtask

  localparam logic [63:0] PAT_A5 = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    int acc;
    n_tests = 0;
    n_fail  = 0;
    bus.i_start = 1'b0;
    bus.i_eta   = 2'd0;
    bus.i_word  = '0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    i_rstn      = 1'b0;
    step();
    step();
    check_reset_outputs("rst");
    i_rstn = 1'b1;
    step();

    // eta=2 continuous fill with words 1..16.
    start_fill(2'd2);
    check("e2_ready_after_start", 64'(bus.o_ready), 64'd1);
    check("e2_busy_after_start",  64'(bus.o_busy),  64'd1);
    bus.i_valid = 1'b1;
    for (int n = 0; n < 16; n++) begin
      bus.i_word = 64'(n + 1);
      step();
      if (n == 14) check("e2_valid_before_last", 64'(bus.o_valid), 64'd0);
    end
    check("e2_valid_after_16", 64'(bus.o_valid), 64'd1);
    check("e2_ready_in_hold",  64'(bus.o_ready), 64'd0);
    check("e2_eta",            64'(bus.o_eta),   64'd2);
    check("e2_upper_zero",     upper_or(),       64'd0);
    for (int n = 0; n < 16; n++) check($sformatf("e2_word%0d", n), word_at(n), 64'(n + 1));

    // Backpressure: 10 cycles in HOLD with i_valid high and a foreign word.
    bus.i_word = 64'hDEAD_BEEF_0BAD_F00D;
    for (int c = 0; c < 10; c++) begin
      step();
      check($sformatf("bp_valid%0d", c), 64'(bus.o_valid), 64'd1);
      check($sformatf("bp_ready%0d", c), 64'(bus.o_ready), 64'd0);
    end
    check("bp_word0",  word_at(0),  64'd1);
    check("bp_word15", word_at(15), 64'd16);
    check("bp_upper",  upper_or(),  64'd0);
    bus.i_valid = 1'b0;

    // Hand-off with a back-to-back eta=3 start.
    bus.i_ready = 1'b1;
    start_fill(2'd3);
    bus.i_ready = 1'b0;
    check("b2b_ready", 64'(bus.o_ready), 64'd1);
    check("b2b_valid", 64'(bus.o_valid), 64'd0);
    check("b2b_clear", all_or(),         64'd0);
    check("b2b_eta",   64'(bus.o_eta),   64'd3);

    // eta=3 fill with i_valid toggling every other cycle.
    acc = 0;
    bus.i_word = PAT_A5;
    for (int c = 0; c < 200 && acc < 24; c++) begin
      bus.i_valid = (c % 2 == 0);
      step();
      if (bus.i_valid) acc++;
      if (acc == 23 && bus.i_valid) check("e3_valid_at_23", 64'(bus.o_valid), 64'd0);
    end
    bus.i_valid = 1'b0;
    check("e3_accepted", 64'(acc), 64'd24);
    check("e3_valid",    64'(bus.o_valid), 64'd1);
    for (int n = 0; n < 24; n++) check($sformatf("e3_word%0d", n), word_at(n), PAT_A5);

    // Illegal start in the hand-off cycle: error pulse and return to IDLE.
    bus.i_ready = 1'b1;
    start_fill(2'd1);
    bus.i_ready = 1'b0;
    check("hoerr_err",   64'(bus.o_err),   64'd1);
    check("hoerr_busy",  64'(bus.o_busy),  64'd0);
    check("hoerr_valid", 64'(bus.o_valid), 64'd0);
    step();
    check("hoerr_err_clear", 64'(bus.o_err), 64'd0);

    // Illegal eta in IDLE.
    start_fill(2'd1);
    check("ill1_err",   64'(bus.o_err),   64'd1);
    check("ill1_busy",  64'(bus.o_busy),  64'd0);
    check("ill1_ready", 64'(bus.o_ready), 64'd0);
    step();
    check("ill1_err_pulse", 64'(bus.o_err), 64'd0);
    start_fill(2'd0);
    check("ill0_err", 64'(bus.o_err), 64'd1);
    step();

    // Start during FILL is ignored and does not disturb the count.
    start_fill(2'd2);
    bus.i_valid = 1'b1;
    for (int n = 0; n < 16; n++) begin
      bus.i_word  = 64'h100 + 64'(n);
      bus.i_start = (n == 5);
      bus.i_eta   = (n == 5) ? 2'd3 : 2'd2;
      step();
      if (n == 5) check("fillstart_err", 64'(bus.o_err), 64'd0);
      if (n == 14) check("fillstart_valid_early", 64'(bus.o_valid), 64'd0);
    end
    bus.i_valid = 1'b0;
    check("fillstart_valid", 64'(bus.o_valid), 64'd1);
    check("fillstart_eta",   64'(bus.o_eta),   64'd2);
    check("fillstart_word5", word_at(5),       64'h105);
    check("fillstart_word15", word_at(15),     64'h10F);
    bus.i_ready = 1'b1;
    step();
    bus.i_ready = 1'b0;
    check("handoff_idle", 64'(bus.o_busy), 64'd0);

    // Reset after 7 accepted words aborts the block.
    start_fill(2'd2);
    bus.i_valid = 1'b1;
    bus.i_word  = 64'h1234_5678_9ABC_DEF0;
    for (int n = 0; n < 7; n++) step();
    bus.i_valid = 1'b0;
    i_rstn = 1'b0;
    step();
    check_reset_outputs("midrst");
    i_rstn = 1'b1;
    step();

    // Fresh eta=2 fill of all-ones words after the abort.
    start_fill(2'd2);
    bus.i_valid = 1'b1;
    bus.i_word  = ONES;
    for (int n = 0; n < 16; n++) step();
    bus.i_valid = 1'b0;
    check("ones_valid", 64'(bus.o_valid), 64'd1);
    for (int n = 0; n < 16; n++) check($sformatf("ones_word%0d", n), word_at(n), ONES);
    check("ones_upper", upper_or(), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cbd_ibuf.md
# cbd_ibuf

Input byte buffer for the centered-binomial sampler. It accepts the 64-bit word stream squeezed from the SHAKE256 PRF and assembles 64·η bytes (128 for η=2, 192 for η=3). It presents the result as one 1536-bit block, together with the latched η, to the downstream `cbd` stage. The block holds a single entry and uses valid/ready handshakes on both sides.

## Interface

One clock; reset is synchronous and active-low.

Parameters:
- `BW_WORD`, 64: width of one PRF output word (one Keccak lane).
- `BW_BUF`, 1536: width of the output byte block (192 bytes × 8).

Ports:
- `i_clk`, input, 1: clock; all state changes on the rising edge.
- `i_rstn`, input, 1: synchronous active-low reset.
- `i_start`, input, 1: begin a new fill; sampled in IDLE, or in the HOLD hand-off cycle.
- `i_eta`, input, 2: η for the fill, latched on an accepted `i_start`. Legal values are 2 and 3.
- `i_word`, input, 64: PRF output word, little-endian bytes.
- `i_valid`, input, 1: `i_word` is valid.
- `o_ready`, output, 1: buffer accepts a word this cycle.
- `o_ibytes`, output, 1536: assembled bytes; byte k sits at bits [8k+7:8k].
- `o_eta`, output, 2: η latched for the current block.
- `o_valid`, output, 1: `o_ibytes` and `o_eta` are complete and stable.
- `i_ready`, input, 1: downstream takes the block.
- `o_busy`, output, 1: state is not IDLE.
- `o_err`, output, 1: one-cycle pulse when `i_start` arrives with an illegal `i_eta`.

## Operation

States:
- **IDLE**
  - `i_start` with `i_eta` ∈ {2,3`}`: latch η, clear the whole buffer to 0, clear the word counter, go to FILL.
  - `i_start` with `i_eta` ∈ {0,1}: pulse `o_err`, stay in IDLE.
- **FILL**
  - `o_ready`=1.
  - Each accepted word (`i_valid && o_ready`) is written to buffer bits [64·cnt+63 : 64·cnt], then cnt increments.
  - The counter is 5 bits. The last word is at cnt = 8·η−1, i.e. 15 for η=2 and 23 for η=3. Accepting it moves the state to HOLD.
- **HOLD**
  - `o_valid`=1, `o_ready`=0, buffer frozen.
  - On `i_valid`/`i_ready` hand-off (`o_valid && i_ready`):
    - with a legal `i_start` in the same cycle: latch the new η, clear the buffer, go to FILL;
    - otherwise go to IDLE.

Rules:
- For η=2, bytes 128–191 read as 0.
- `i_start` in FILL is ignored: no restart, no `o_err`. `i_start` in HOLD without hand-off is also ignored.
- `o_err` fires for an illegal η only when the start would otherwise have been accepted: IDLE, or the HOLD hand-off cycle. An illegal start in the hand-off cycle still returns the state to IDLE.
- `i_word` is ignored whenever `o_ready`=0.
- Buffer contents and `o_eta` are undefined-but-stable outside HOLD. Downstream uses them only while `o_valid`=1.

## Timing

- Reset values: state IDLE; `o_ready`, `o_valid`, `o_busy`, `o_err` = 0; `o_ibytes` = 0; `o_eta` = 0; counter 0.
- Reset asserted mid-fill or in HOLD aborts the block. Everything returns to reset values on that edge and no partial block is ever presented.
- All outputs are registered or decoded from registered state. There is no combinational path from `i_valid` or `i_ready` to any output.
- Start accepted at edge t: `o_ready`=1 from t+1.
- With `i_valid` held high, the last word is accepted at edge t+8η and `o_valid`=1 from t+8η+1. That is 16 words for η=2 and 24 for η=3, one word per cycle, with no bubble required.
- Throughput, with a back-to-back start in the hand-off cycle: one block per 8η+1 cycles.
- `o_valid` stays high until hand-off, however long `i_ready` is held low. `o_ibytes` does not change while `o_valid`=1.

## Structure

- Shared package `kyber_pkg`:
  - `KYBER_N`=256;
  - `ETA_MAX`=3;
  - `BW_WORD`=64;
  - `BW_BUF`=1536;
  - state encoding (IDLE/FILL/HOLD);
  - function `words_for_eta(eta)` = 8·eta.
- Single module; no sub-module is warranted. The word write is a 24-way decoded register enable.

## Test plan

- **η=2 fill:** reset, start η=2, feed words 0x0001…0x0010 continuously.
  - `o_valid` rises 17 cycles after the start edge.
  - Word n sits at bits [64n+63:64n].
  - Bits [1535:1024] = 0; `o_eta`=2.
- **η=3 fill with gaps:** start η=3, feed 24 words of 0xA5A5A5A5A5A5A5A5 with `i_valid` toggling every other cycle.
  - All 1536 bits equal the pattern.
  - `o_valid` asserts only after the 24th accepted word.
- **Backpressure and back-to-back:** hold `i_ready`=0 for 10 cycles in HOLD.
  - `o_valid` stays 1, `o_ibytes` is unchanged, and `o_ready`=0 even with `i_valid`=1.
  - Then assert `i_ready` and `i_start` (η=2) together: the next cycle is FILL with counter 0 and the buffer cleared.
- **Illegal η:** `i_start` with η=1 in IDLE.
  - `o_err` pulses for exactly 1 cycle; state stays IDLE; `o_busy`=0.
  - `i_start` with η=3 during FILL: ignored, counter unaffected, `o_err`=0.
- **Reset mid-fill:** drop `i_rstn` after 7 accepted words.
  - All outputs return to reset values.
  - A following η=2 fill of 16 words of 0xFF…FF yields bits [1023:0] all ones and bits [1535:1024] all zero.
- **Sampler golden model:** 50 random η/seed vectors.
  - Each `o_ibytes` equals the first 64η bytes of the SHAKE256 reference stream.
  - Feeding `o_ibytes`/`o_eta` into `cbd` reproduces the golden `o_coeffs` vectors.
